// File: rtl/audio_dac_stream.sv
// Stereo sample FIFO feeding a WM8731 in I2S slave mode; this block drives BCLK and DACLRCK.
// Optional AUDIO_DAC_UNDERRUN_HOLD_EN: repeat the last frame on underrun instead of silence.
module audio_dac_stream #(
   parameter int BCLK_DIV   = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                               i_clk,
   input  logic                               i_rst_n,
   input  logic                               i_en,
   input  logic [31:0]                        i_data,
   input  logic                               i_valid,
   output logic                               o_ready,
   output logic                               o_aud_bclk,
   output logic                               o_aud_daclrck,
   output logic                               o_aud_dacdat,
   output logic                               o_underrun,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_fifo_level
);

   localparam int LW = $clog2(FIFO_DEPTH + 1);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int DW = $clog2(BCLK_DIV);

   typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

   state_t        r_state;
   logic [31:0]   r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [LW-1:0] r_level;
   logic [DW-1:0] r_div_cnt;
   logic [5:0]    r_bit_cnt;
   logic [31:0]   r_frame;
   logic          r_bclk;
   logic          r_dacdat;
   logic          r_underrun;

   logic       w_full;
   logic       w_empty;
   logic       w_push;
   logic       w_pop;
   logic       w_tick;
   logic       w_fall;
   logic       w_frame_start;
   logic       w_flush;
   logic [5:0] w_bit_nxt;
   logic       w_bit_val;

   assign w_full        = (r_level == LW'(FIFO_DEPTH));
   assign w_empty       = (r_level == '0);
   assign o_ready       = (r_state != IDLE) && !w_full;
   assign w_push        = i_valid && o_ready;
   assign w_flush       = (r_state == IDLE) || !i_en;
   assign w_tick        = (r_div_cnt == DW'(BCLK_DIV - 1));
   assign w_fall        = (r_state == RUN) && w_tick && r_bclk;
   assign w_bit_nxt     = r_bit_cnt + 6'd1;
   assign w_frame_start = w_fall && (w_bit_nxt == 6'd0);
   // A push landing on an empty FIFO at frame start is not forwarded; it waits a frame.
   assign w_pop         = w_frame_start && !w_empty;

   // I2S slot map: MSB one BCLK after the LRCK edge, 16 data bits, zero padding.
   always_comb begin
      w_bit_val = 1'b0;
      if (w_bit_nxt >= 6'd1 && w_bit_nxt <= 6'd16)
         w_bit_val = r_frame[5'(6'd32 - w_bit_nxt)];
      else if (w_bit_nxt >= 6'd33 && w_bit_nxt <= 6'd48)
         w_bit_val = r_frame[5'(6'd48 - w_bit_nxt)];
   end

   always_ff @(posedge i_clk) begin
      if (w_push)
         r_mem[r_wr_ptr] <= i_data;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state    <= IDLE;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= '0;
         r_div_cnt  <= '0;
         r_bit_cnt  <= '0;
         r_frame    <= '0;
         r_bclk     <= 1'b0;
         r_dacdat   <= 1'b0;
         r_underrun <= 1'b0;
      end else begin
         r_underrun <= 1'b0;
         if (w_flush) begin
            // Stop aborts mid-frame: clocks and data drop on this edge.
            r_state   <= (r_state == IDLE && i_en) ? PRIME : IDLE;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_frame   <= '0;
            r_bclk    <= 1'b0;
            r_dacdat  <= 1'b0;
         end else begin
            if (w_push)
               r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
               r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)
               r_level <= r_level + LW'(1);
            else if (!w_push && w_pop)
               r_level <= r_level - LW'(1);

            if (r_state == PRIME) begin
               if (r_level >= LW'(FIFO_DEPTH / 2)) begin
                  r_state   <= RUN;
                  r_bclk    <= 1'b1;
                  r_bit_cnt <= 6'd63;
                  r_div_cnt <= '0;
                  r_frame   <= '0;
               end
            end else begin
               if (w_tick) begin
                  r_div_cnt <= '0;
                  r_bclk    <= !r_bclk;
               end else begin
                  r_div_cnt <= r_div_cnt + DW'(1);
               end
               if (w_fall) begin
                  r_bit_cnt <= w_bit_nxt;
                  r_dacdat  <= w_bit_val;
               end
               if (w_frame_start) begin
                  if (!w_empty) begin
                     r_frame <= r_mem[r_rd_ptr];
                  end else begin
                     r_underrun <= 1'b1;
`ifdef AUDIO_DAC_UNDERRUN_HOLD_EN
                     r_frame <= r_frame;
`else
                     r_frame <= '0;
`endif
                  end
               end
            end
         end
      end
   end

   assign o_aud_bclk    = r_bclk;
   assign o_aud_daclrck = r_bit_cnt[5];
   assign o_aud_dacdat  = r_dacdat;
   assign o_underrun    = r_underrun;
   assign o_fifo_level  = r_level;

endmodule

// File: tb/tb_audio_dac_stream.sv
// Directed bench for audio_dac_stream: reset, priming, I2S framing, backpressure, underrun, stop, reset.
module tb_audio_dac_stream;

   localparam int BCLK_DIV   = 2;
   localparam int FIFO_DEPTH = 4;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic [31:0] data;
   logic        valid;
   logic        ready;
   logic        bclk;
   logic        lrck;
   logic        dacdat;
   logic        underrun;
   logic [2:0]  level;

   audio_dac_stream #(.BCLK_DIV(BCLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_en          (en),
      .i_data        (data),
      .i_valid       (valid),
      .o_ready       (ready),
      .o_aud_bclk    (bclk),
      .o_aud_daclrck (lrck),
      .o_aud_dacdat  (dacdat),
      .o_underrun    (underrun),
      .o_fifo_level  (level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Frame capture on BCLK rising edges; slot 0 is the first rise after LRCK falls.
   int          slot = -1;
   int          gap = 0;
   int          cap_n = 0;
   int          ur_cycles = 0;
   logic        prev_bclk = 1'b0;
   logic        prev_rise_lrck = 1'b0;
   logic [63:0] fbits = '0;
   logic [15:0] cap_l [32];
   logic [15:0] cap_r [32];
   logic        cap_pad [32];

   always @(negedge clk) begin
      if (underrun) ur_cycles++;
      gap++;
      if (bclk && !prev_bclk) begin
         if (gap > 2 * BCLK_DIV + 1) slot = -1;
         gap = 0;
         if (!lrck && prev_rise_lrck) slot = 0;
         else if (slot >= 0 && slot < 63) slot++;
         else slot = -1;
         prev_rise_lrck = lrck;
         if (slot >= 0) begin
            fbits[slot] = dacdat;
            if (slot == 63 && cap_n < 32) begin
               cap_pad[cap_n] = 1'b0;
               for (int j = 0; j < 64; j++)
                  if (!((j >= 1 && j <= 16) || (j >= 33 && j <= 48)) && fbits[j])
                     cap_pad[cap_n] = 1'b1;
               for (int j = 0; j < 16; j++) begin
                  cap_l[cap_n][j] = fbits[16 - j];
                  cap_r[cap_n][j] = fbits[48 - j];
               end
            end
            if (slot == 63) cap_n++;
         end
      end
      prev_bclk = bclk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cap(input int n, input int lim, input string tag);
      int t;
      t = 0;
      while (cap_n < n && t < lim) begin tick(); t++; end
      chk(tag, 64'(cap_n >= n), 1);
   endtask

   task automatic wait_slot(input int s, input int lim, input string tag);
      int t;
      t = 0;
      while (slot != s && t < lim) begin tick(); t++; end
      chk(tag, 64'(slot == s), 1);
   endtask

   task automatic chk_frame(input int i, input string tag, input logic [15:0] l, input logic [15:0] r);
      chk({tag, "_left"}, cap_l[i], l);
      chk({tag, "_right"}, cap_r[i], r);
      chk({tag, "_pad"}, cap_pad[i], 0);
   endtask

   logic [31:0] bp [6];
   logic [15:0] exp_l3, exp_r3;

   initial begin
      int nz, t, idx, base;
      logic fire, saw_full;
      bp[0] = 32'hA5A5_0F0F; bp[1] = 32'h0001_8000; bp[2] = 32'hFFFF_0000;
      bp[3] = 32'h7FFF_8001; bp[4] = 32'h1357_9BDF; bp[5] = 32'hCAFE_BEEF;
`ifdef AUDIO_DAC_UNDERRUN_HOLD_EN
      exp_l3 = 16'h1234; exp_r3 = 16'h5678;
`else
      exp_l3 = 16'h0000; exp_r3 = 16'h0000;
`endif
      rst_n = 1'b0; en = 1'b0; valid = 1'b0; data = '0;
      repeat (3) tick();
      chk("rst_bclk", bclk, 0);
      chk("rst_lrck", lrck, 0);
      chk("rst_dat", dacdat, 0);
      chk("rst_underrun", underrun, 0);
      chk("rst_ready", ready, 0);
      chk("rst_level", level, 0);
      rst_n = 1'b1;
      nz = 0;
      for (int i = 0; i < 1000; i++) begin
         tick();
         if (bclk || lrck || dacdat || ready || underrun) nz++;
      end
      chk("idle_static", nz, 0);

      // Prime with two samples, then first frame
      en = 1'b1;
      tick();
      chk("prime_ready", ready, 1);
      chk("prime_level0", level, 0);
      valid = 1'b1; data = 32'h8001_7FFE;
      tick();
      chk("prime_level1", level, 1);
      data = 32'h1234_5678;
      tick();
      valid = 1'b0;
      chk("prime_level2", level, 2);
      chk("prime_bclk_stopped", bclk, 0);
      tick();
      chk("run_entry_bclk", bclk, 1);
      chk("run_entry_lrck", lrck, 1);
      tick();
      chk("run_hold_bclk", bclk, 1);
      tick();
      chk("fstart_bclk", bclk, 0);
      chk("fstart_lrck", lrck, 0);
      chk("fstart_level", level, 1);
      chk("fstart_no_underrun", underrun, 0);
      wait_cap(1, 400, "frame0_tmo");
      chk_frame(0, "frame0", 16'h8001, 16'h7FFE);
      wait_cap(2, 400, "frame1_tmo");
      chk_frame(1, "frame1", 16'h1234, 16'h5678);

      // Third frame start finds the FIFO empty
      t = 0;
      while (!underrun && t < 600) begin tick(); t++; end
      chk("ur_seen", underrun, 1);
      chk("ur_level", level, 0);
      tick();
      chk("ur_one_cycle", underrun, 0);
      chk("ur_count", ur_cycles, 1);
      wait_cap(3, 400, "frame2_tmo");
      chk_frame(2, "frame2_ur", exp_l3, exp_r3);

      // Stop mid-frame at bit 20 with data buffered
      valid = 1'b1; data = 32'h0BAD_F00D;
      tick();
      data = 32'h0BAD_F00E;
      tick();
      valid = 1'b0;
      wait_slot(19, 400, "stop_slot_tmo");
      repeat (3) tick();
      chk("stop_pre_bclk", bclk, 1);
      chk("stop_pre_level", 64'(level != 0), 1);
      en = 1'b0;
      tick();
      chk("stop_bclk", bclk, 0);
      chk("stop_lrck", lrck, 0);
      chk("stop_dat", dacdat, 0);
      chk("stop_level", level, 0);
      chk("stop_ready", ready, 0);
      en = 1'b1;
      tick();
      chk("reprime_ready", ready, 1);
      chk("reprime_level", level, 0);
      repeat (10) tick();
      chk("reprime_bclk", bclk, 0);

      // Backpressure: six samples pushed while FIFO fills
      base = cap_n;
      idx = 0; valid = 1'b1; data = bp[0]; saw_full = 1'b0; t = 0;
      while (idx < 6 && t < 800) begin
         fire = ready;
         tick(); t++;
         if (fire) begin
            idx++;
            if (idx < 6) data = bp[idx];
            else valid = 1'b0;
         end
         if (level == 3'd4) begin
            chk("bp_ready_full", ready, 0);
            saw_full = 1'b1;
         end
      end
      valid = 1'b0;
      chk("bp_all_pushed", idx, 6);
      chk("bp_saw_full", saw_full, 1);
      wait_cap(base + 6, 2200, "bp_frames_tmo");
      for (int i = 0; i < 6; i++)
         chk_frame(base + i, $sformatf("bp_frame%0d", i), bp[i][31:16], bp[i][15:0]);

      // Reset during the right channel
      wait_slot(40, 400, "rst_slot_tmo");
      chk("rstmid_pre_lrck", lrck, 1);
      valid = 1'b1; data = 32'h5555_AAAA;
      tick();
      valid = 1'b0;
      chk("rstmid_pre_level", level, 1);
      rst_n = 1'b0;
      tick();
      chk("rstmid_bclk", bclk, 0);
      chk("rstmid_lrck", lrck, 0);
      chk("rstmid_dat", dacdat, 0);
      chk("rstmid_level", level, 0);
      chk("rstmid_ready", ready, 0);
      chk("rstmid_underrun", underrun, 0);
      rst_n = 1'b1; en = 1'b0;
      repeat (5) tick();
      chk("post_rst_bclk", bclk, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
